// File: rtl/qar_mem_pkg.sv
// Shared types and constants for the QAR-Core data-memory responder.
package qar_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        TURN = 2'd3
    } state_e;

    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    localparam int          WAIT_FIXED = 0;
    localparam int          WAIT_LFSR  = 1;

    // One step of the right-shifting Galois LFSR (taps 16,14,13,11).
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

endpackage

// File: rtl/qar_lfsr16.sv
// 16-bit Galois LFSR used to draw pseudo-random wait counts.
module qar_lfsr16
    import qar_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    logic [15:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (advance) value_d = lfsr_next(value_q);
    end

    always_ff @(posedge clk) begin
        if (rst) value_q <= seed;
        else     value_q <= value_d;
    end

    assign value = value_q;

endmodule

// File: rtl/qar_dmem_responder.sv
// Data-memory responder for the QAR-Core external port: internal RAM,
// programmable wait states, access counters and a sticky out-of-range flag.
module qar_dmem_responder
    import qar_mem_pkg::*;
#(
    parameter int          DEPTH      = 256,
    parameter int          ADDR_WIDTH = 8,
    parameter int          WAIT_MODE  = 0,
    parameter int          FIXED_WAIT = 0,
    parameter logic [3:0]  RAND_MASK  = 4'h3,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic        err_oob
);

    state_e      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH];

    logic [15:0]           lfsr_val;
    logic                  lfsr_adv;
    logic                  req_we;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic                  req_oob;
    logic [ADDR_WIDTH-1:0] req_idx;
    logic [3:0]            wait_init;
    logic                  enter_resp;
    logic                  ram_wr;

    qar_lfsr16 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .advance (lfsr_adv),
        .seed    (LFSR_SEED),
        .value   (lfsr_val)
    );

    // A zero-wait request enters RESP on its capture edge, so the commit
    // must see the live port values in IDLE and the latched copy afterwards.
    always_comb begin
        req_we    = (state_q == IDLE) ? mem_we    : we_q;
        req_addr  = (state_q == IDLE) ? mem_addr  : addr_q;
        req_wdata = (state_q == IDLE) ? mem_wdata : wdata_q;
        req_oob   = |req_addr[31:ADDR_WIDTH+2];
        req_idx   = req_addr[ADDR_WIDTH+1:2];
        wait_init = (WAIT_MODE == WAIT_LFSR) ? (lfsr_val[3:0] & RAND_MASK)
                                             : 4'(FIXED_WAIT);
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        err_d      = err_q;
        lfsr_adv   = 1'b0;
        enter_resp = 1'b0;
        ram_wr     = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_valid) begin
                    we_d     = mem_we;
                    addr_d   = mem_addr;
                    wdata_d  = mem_wdata;
                    lfsr_adv = 1'b1;
                    if (wait_init != 4'd0) begin
                        wait_d  = wait_init;
                        state_d = WAIT;
                    end else begin
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                wait_d = wait_q - 4'd1;
                if (wait_q == 4'd1) enter_resp = 1'b1;
            end
            RESP:    state_d = TURN;
            default: state_d = IDLE;
        endcase

        if (enter_resp) begin
            state_d = RESP;
            if (req_oob) err_d = 1'b1;
            if (req_we) begin
                wr_cnt_d = wr_cnt_q + 16'd1;
                ram_wr   = !req_oob;
            end else begin
                rd_cnt_d = rd_cnt_q + 16'd1;
                rdata_d  = req_oob ? 32'h0 : mem_q[req_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wait_q   <= 4'd0;
            we_q     <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            rd_cnt_q <= 16'h0;
            wr_cnt_q <= 16'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            err_q    <= err_d;
        end
    end

    // RAM contents survive reset; only the in-flight write is suppressed.
    always_ff @(posedge clk) begin
        if (!rst && ram_wr) mem_q[req_idx] <= req_wdata;
    end

    assign mem_ready = (state_q == RESP);
    assign mem_rdata = rdata_q;
    assign rd_count  = rd_cnt_q;
    assign wr_count  = wr_cnt_q;
    assign err_oob   = err_q;

    logic unused_ok;
    assign unused_ok = ^{req_addr[1:0], lfsr_val[15:4]};

endmodule

// File: tb/tb_qar_dmem_responder.sv
// Directed bench: three responders (fixed wait 0, fixed wait 3, LFSR wait).
module tb_qar_dmem_responder;

    logic        clk = 1'b0;
    logic        rst     [3];
    logic        valid   [3];
    logic        we_i    [3];
    logic [31:0] addr_i  [3];
    logic [31:0] wdata_i [3];
    logic        ready   [3];
    logic [31:0] rdata   [3];
    logic [15:0] rd_cnt  [3];
    logic [15:0] wr_cnt  [3];
    logic        err     [3];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        qar_dmem_responder #(
            .WAIT_MODE  ((g == 2) ? 1 : 0),
            .FIXED_WAIT ((g == 1) ? 3 : 0)
        ) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .mem_valid (valid[g]),
            .mem_we    (we_i[g]),
            .mem_addr  (addr_i[g]),
            .mem_wdata (wdata_i[g]),
            .mem_ready (ready[g]),
            .mem_rdata (rdata[g]),
            .rd_count  (rd_cnt[g]),
            .wr_count  (wr_cnt[g]),
            .err_oob   (err[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request; lat = edges after the capture edge before mem_ready is seen.
    task automatic do_req(input int d, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input bit hold,
                          output logic [31:0] rd, output int lat);
        @(negedge clk);
        valid[d] = 1'b1; we_i[d] = we; addr_i[d] = addr; wdata_i[d] = wd;
        @(posedge clk); #1;
        lat = 0;
        while (ready[d] !== 1'b1 && lat < 32) begin
            @(posedge clk); #1;
            lat++;
        end
        if (ready[d] !== 1'b1) chk("ready_timeout", {31'b0, ready[d]}, 32'h1);
        rd = rdata[d];
        if (!hold) begin
            @(negedge clk); valid[d] = 1'b0; we_i[d] = 1'b0;
        end
        @(posedge clk); #1;
        chk("ready_turn", {31'b0, ready[d]}, 32'h0);
        @(posedge clk);
        if (hold) begin
            @(negedge clk); valid[d] = 1'b0; we_i[d] = 1'b0;
        end
    endtask

    function automatic logic [15:0] ref_lfsr(input logic [15:0] v);
        logic [15:0] s;
        s = {1'b0, v[15:1]};
        if (v[0]) s = s ^ 16'hB400;
        return s;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int          lat;
        int          pulses;
        logic [15:0] lfsr;
        logic [31:0] model [256];
        int          wlist [$];
        bit          seen  [256];

        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; valid[d] = 1'b0; we_i[d] = 1'b0;
            addr_i[d] = 32'h0; wdata_i[d] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_ready", {31'b0, ready[d]}, 32'h0);
            chk("rst_rdata", rdata[d], 32'h0);
            chk("rst_rdcnt", {16'b0, rd_cnt[d]}, 32'h0);
            chk("rst_wrcnt", {16'b0, wr_cnt[d]}, 32'h0);
            chk("rst_err", {31'b0, err[d]}, 32'h0);
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;

        // Zero wait: basic store/load, byte-offset ignore, out-of-range handling
        do_req(0, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0, rd, lat);
        chk("w0_st_lat", lat, 0);
        do_req(0, 1'b0, 32'h40, 32'h0, 1'b0, rd, lat);
        chk("w0_ld_lat", lat, 0);
        chk("w0_ld_data", rd, 32'hDEADBEEF);
        chk("w0_wrcnt", {16'b0, wr_cnt[0]}, 32'd1);
        chk("w0_rdcnt", {16'b0, rd_cnt[0]}, 32'd1);
        do_req(0, 1'b1, 32'h0, 32'h11111111, 1'b0, rd, lat);
        chk("w0_st_keeps_rdata", rdata[0], 32'hDEADBEEF);
        do_req(0, 1'b0, 32'h43, 32'h0, 1'b0, rd, lat);
        chk("w0_byteoff_data", rd, 32'hDEADBEEF);
        do_req(0, 1'b1, 32'h400, 32'h22222222, 1'b0, rd, lat);
        chk("oob_st_lat", lat, 0);
        chk("oob_err_set", {31'b0, err[0]}, 32'h1);
        do_req(0, 1'b0, 32'h400, 32'h0, 1'b0, rd, lat);
        chk("oob_ld_lat", lat, 0);
        chk("oob_ld_data", rd, 32'h0);
        do_req(0, 1'b0, 32'h0, 32'h0, 1'b0, rd, lat);
        chk("oob_word0_kept", rd, 32'h11111111);
        chk("oob_err_sticky", {31'b0, err[0]}, 32'h1);
        chk("oob_wrcnt", {16'b0, wr_cnt[0]}, 32'd3);
        chk("oob_rdcnt", {16'b0, rd_cnt[0]}, 32'd4);

        // Fixed wait 3: latency, valid held through TURN, WAIT-time port changes
        do_req(1, 1'b0, 32'h0, 32'h0, 1'b1, rd, lat);
        chk("w3_ld_lat", lat, 3);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (ready[1] === 1'b1) pulses++;
        end
        chk("w3_hold_pulses", pulses, 0);
        chk("w3_hold_rdcnt", {16'b0, rd_cnt[1]}, 32'd1);

        do_req(1, 1'b1, 32'h24, 32'h24242424, 1'b0, rd, lat);
        @(negedge clk);
        valid[1] = 1'b1; we_i[1] = 1'b1; addr_i[1] = 32'h20; wdata_i[1] = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        we_i[1] = 1'b1; addr_i[1] = 32'h24; wdata_i[1] = 32'h0BAD0BAD;
        lat = 0;
        while (ready[1] !== 1'b1 && lat < 32) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("w3_chg_lat", lat, 3);
        @(negedge clk); valid[1] = 1'b0; we_i[1] = 1'b0;
        repeat (2) @(posedge clk);
        do_req(1, 1'b0, 32'h20, 32'h0, 1'b0, rd, lat);
        chk("w3_latched_data", rd, 32'hCAFEF00D);
        do_req(1, 1'b0, 32'h24, 32'h0, 1'b0, rd, lat);
        chk("w3_other_kept", rd, 32'h24242424);

        // Reset in the middle of a store's wait period
        do_req(1, 1'b1, 32'h10, 32'hAAAA5555, 1'b0, rd, lat);
        do_req(1, 1'b0, 32'h10, 32'h0, 1'b0, rd, lat);
        @(negedge clk);
        valid[1] = 1'b1; we_i[1] = 1'b1; addr_i[1] = 32'h10; wdata_i[1] = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        rst[1] = 1'b1; valid[1] = 1'b0; we_i[1] = 1'b0;
        @(posedge clk); #1;
        chk("mrst_ready", {31'b0, ready[1]}, 32'h0);
        chk("mrst_rdata", rdata[1], 32'h0);
        chk("mrst_rdcnt", {16'b0, rd_cnt[1]}, 32'h0);
        chk("mrst_wrcnt", {16'b0, wr_cnt[1]}, 32'h0);
        @(negedge clk); rst[1] = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ready[1] === 1'b1) pulses++;
        end
        chk("mrst_pulses", pulses, 0);
        do_req(1, 1'b0, 32'h10, 32'h0, 1'b0, rd, lat);
        chk("mrst_ram_kept", rd, 32'hAAAA5555);
        chk("mrst_after_lat", lat, 3);

        // LFSR wait: random store/load pairs against scoreboard + reference LFSR
        lfsr = 16'hACE1;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        for (int i = 0; i < 200; i++) begin
            int          a, b;
            logic [31:0] data;
            a = $urandom_range(0, 255);
            data = $urandom;
            do_req(2, 1'b1, 32'(a) << 2, data, 1'b0, rd, lat);
            chk("rnd_st_wait", lat, {28'b0, lfsr[3:0] & 4'h3});
            lfsr = ref_lfsr(lfsr);
            model[a] = data;
            if (!seen[a]) begin
                seen[a] = 1'b1;
                wlist.push_back(a);
            end
            b = wlist[$urandom_range(0, wlist.size() - 1)];
            do_req(2, 1'b0, (32'(b) << 2) | 32'($urandom_range(0, 3)), 32'h0, 1'b0, rd, lat);
            chk("rnd_ld_wait", lat, {28'b0, lfsr[3:0] & 4'h3});
            lfsr = ref_lfsr(lfsr);
            chk("rnd_ld_data", rd, model[b]);
        end
        chk("rnd_rdcnt", {16'b0, rd_cnt[2]}, 32'd200);
        chk("rnd_wrcnt", {16'b0, wr_cnt[2]}, 32'd200);
        chk("rnd_err", {31'b0, err[2]}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/qar_dmem_responder.md
Name: qar_dmem_responder

Overview:
Synthesizable data-memory responder for the QAR-Core external data port (mem_valid/mem_we/mem_addr/mem_wdata/mem_ready/mem_rdata).
- Answers core load/store requests from an internal word-addressed RAM.
- Inserts programmable wait states, fixed or pseudo-random, so FPGA builds can stress the core's stall logic the same way simulation does.
- Sits between qar_core (USE_INTERNAL_DMEM=0) and the SoC top; exposes access counters and an out-of-range error flag.

Parameters:
DEPTH, 256, RAM size in 32-bit words.
ADDR_WIDTH, 8, word-index width; DEPTH == 2**ADDR_WIDTH.
WAIT_MODE, 0, 0 = fixed wait, 1 = LFSR-random wait.
FIXED_WAIT, 0, wait cycles in mode 0 (0..15).
RAND_MASK, 4'h3, mask applied to LFSR bits for the mode-1 wait count (max 15).
LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
mem_valid  in  1  core request; held until mem_ready seen
mem_we  in  1  1 = store, 0 = load
mem_addr  in  32  byte address; bits [1:0] ignored
mem_wdata  in  32  store data
mem_ready  out  1  one-cycle completion pulse
mem_rdata  out  32  load data, valid while mem_ready=1
rd_count  out  16  completed loads, wraps
wr_count  out  16  completed stores, wraps
err_oob  out  1  sticky: an out-of-range access occurred

Behaviour:
- Reset (rst=1 at an edge):
  - mem_ready=0, mem_rdata=0, rd_count=0, wr_count=0, err_oob=0, state=IDLE, LFSR=LFSR_SEED.
  - RAM contents are NOT cleared.
  - A request in flight is aborted: no write commits and no mem_ready pulse.
- States: IDLE, WAIT, RESP, TURN.
- IDLE:
  - On an edge with mem_valid=1, latch we/addr/wdata.
  - Load wait counter W: FIXED_WAIT, or (lfsr[3:0] & RAND_MASK).
  - LFSR advances once per accepted request.
  - Go to WAIT if W>0, else RESP.
- WAIT: decrement W each edge; go to RESP when W reaches 1.
- RESP:
  - mem_ready=1 for exactly this cycle.
  - Store: RAM write commits at the edge entering RESP.
  - Load: mem_rdata is registered at that same edge.
  - Next state is TURN.
- Latency: with W=0, mem_ready rises the cycle after capture. Each wait cycle adds one cycle.
- TURN:
  - One cycle; mem_valid is ignored here, so the request just completed is never recaptured.
  - Returns to IDLE. Back-to-back requests are therefore accepted every W+3 cycles at best.
- mem_we, mem_addr and mem_wdata changing while in WAIT are ignored; only latched values are used.
- mem_rdata holds its last value outside RESP. Stores do not alter mem_rdata.
- Out of range (latched addr[31:ADDR_WIDTH+2] != 0):
  - Handshake completes normally with the same latency.
  - Store is dropped; load returns 32'h0.
  - err_oob set and sticky until rst.
  - Counters still increment.
- Counters increment at the edge entering RESP and wrap 16'hFFFF -> 0.
- LFSR: 16-bit Galois, taps 16,14,13,11 (mask 16'hB400). Never reaches 0 given a nonzero seed.

Decomposition:
- Package qar_mem_pkg:
  - state enum (IDLE, WAIT, RESP, TURN);
  - LFSR_TAPS = 16'hB400;
  - WAIT_FIXED / WAIT_LFSR mode constants.
- One sub-module, qar_lfsr16: ports clk, rst, advance, seed, value.
- RAM array, FSM and counters stay in the top module.

Test Plan:
- Fixed wait 0: store 32'hDEADBEEF to 0x40, then load 0x40 -> mem_ready exactly 1 cycle after each capture; mem_rdata=32'hDEADBEEF; wr_count=1, rd_count=1.
- FIXED_WAIT=3: load 0x0 -> mem_ready rises on the 4th cycle after capture; mem_valid held high through TURN yields only one pulse and rd_count=1.
- WAIT_MODE=1, seed 16'hACE1, 200 random load/store pairs checked against a scoreboard -> all data matches; every wait count is in 0..3 and matches a reference LFSR model.
- Out of range: store to 0x400 then load 0x400 -> both complete; load returns 0; err_oob=1 stays high; word 0 is unchanged.
- rst asserted during WAIT of a store to 0x10 -> no mem_ready pulse; RAM[4] keeps its old value; all outputs return to reset values the next cycle.
- Preload rd_count near wrap via 65536 loads -> rd_count wraps to 0; no effect on the handshake.
